// File: rtl/rpn_eval.sv
//==============================================================================
// Module      : rpn_eval
// Description : Reverse-Polish expression engine driving an attached 16-bit
//               stack. Operands are pushed, binary operators pop two entries
//               and push the result, EQ pops the final value and checks that
//               the stack is empty. Overflow, underflow, leftover entries and
//               illegal opcodes raise err and drain the stack.
//
//   Ports     : clk, reset (sync, active-high)
//               tok_valid/tok_ready/tok_kind/tok_data  token stream in
//               result_valid/result                    one result per EQ
//               err/err_code                           error pulse + code
//               stk_push/stk_pop/stk_value_in          stack command out
//               stk_value_out/stk_full/stk_empty       stack status in
//
//   Options   : RPN_EVAL_SAT_EN defined -> ADD/SUB saturate as signed 16-bit
//               values; otherwise they wrap modulo 2^16.
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rpn_eval (
    input  logic        clk,
    input  logic        reset,
    input  logic        tok_valid,
    output logic        tok_ready,
    input  logic        tok_kind,
    input  logic [15:0] tok_data,
    output logic        result_valid,
    output logic [15:0] result,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        stk_push,
    output logic        stk_pop,
    output logic [15:0] stk_value_in,
    input  logic [15:0] stk_value_out,
    input  logic        stk_full,
    input  logic        stk_empty
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_POP_B  = 3'd1;
    localparam logic [2:0] c_ST_POP_A  = 3'd2;
    localparam logic [2:0] c_ST_PUSH_R = 3'd3;
    localparam logic [2:0] c_ST_POP_F  = 3'd4;
    localparam logic [2:0] c_ST_CHECK  = 3'd5;
    localparam logic [2:0] c_ST_DRAIN  = 3'd6;

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_MUL = 3'd2;
    localparam logic [2:0] c_OP_AND = 3'd3;
    localparam logic [2:0] c_OP_OR  = 3'd4;
    localparam logic [2:0] c_OP_XOR = 3'd5;
    localparam logic [2:0] c_OP_ILL = 3'd6;
    localparam logic [2:0] c_OP_EQ  = 3'd7;

    localparam logic [1:0] c_ERR_OVF  = 2'd0;
    localparam logic [1:0] c_ERR_UNF  = 2'd1;
    localparam logic [1:0] c_ERR_LEFT = 2'd2;
    localparam logic [1:0] c_ERR_ILL  = 2'd3;

    logic [2:0]  r_state;
    logic [2:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_result;
    logic        r_result_valid;
    logic        r_err;
    logic [1:0]  r_err_code;

    logic        w_accept;
    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic [15:0] w_add;
    logic [15:0] w_sub;
    logic [15:0] w_alu;
    logic        w_push;
    logic        w_pop;
    logic [15:0] w_value_in;

    assign tok_ready = (r_state == c_ST_IDLE) && !reset;
    assign w_accept  = tok_valid && tok_ready;

    // One extra sign bit: bits [16] and [15] differ exactly on signed overflow.
    assign w_sum  = {r_a[15], r_a} + {r_b[15], r_b};
    assign w_diff = {r_a[15], r_a} - {r_b[15], r_b};

`ifdef RPN_EVAL_SAT_EN
    assign w_add = (w_sum[16] != w_sum[15])
                 ? (w_sum[16] ? 16'h8000 : 16'h7FFF) : w_sum[15:0];
    assign w_sub = (w_diff[16] != w_diff[15])
                 ? (w_diff[16] ? 16'h8000 : 16'h7FFF) : w_diff[15:0];
`else
    assign w_add = w_sum[15:0];
    assign w_sub = w_diff[15:0];
`endif

    always_comb begin
        w_alu = 16'h0000;
        case (r_op)
            c_OP_ADD: w_alu = w_add;
            c_OP_SUB: w_alu = w_sub;
            c_OP_MUL: w_alu = r_a * r_b;
            c_OP_AND: w_alu = r_a & r_b;
            c_OP_OR:  w_alu = r_a | r_b;
            c_OP_XOR: w_alu = r_a ^ r_b;
            default:  w_alu = 16'h0000;
        endcase
    end

    // Stack commands are combinational so the stack acts on the same edge
    // the decision is made; this keeps stk_full current for back-to-back
    // operands and lets each pop state sample the value exposed by the
    // previous pop.
    always_comb begin
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_value_in = 16'h0000;
        if (!reset) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept && !tok_kind && !stk_full) begin
                        w_push     = 1'b1;
                        w_value_in = tok_data;
                    end
                end
                c_ST_POP_B, c_ST_POP_A, c_ST_POP_F: w_pop = !stk_empty;
                c_ST_PUSH_R: begin
                    w_push     = 1'b1;
                    w_value_in = w_alu;
                end
                c_ST_DRAIN: w_pop = !stk_empty;
                default: begin
                    w_push = 1'b0;
                    w_pop  = 1'b0;
                end
            endcase
        end
    end

    assign stk_push     = w_push;
    assign stk_pop      = w_pop;
    assign stk_value_in = w_value_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_op           <= 3'd0;
            r_a            <= 16'h0000;
            r_b            <= 16'h0000;
            r_result       <= 16'h0000;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_err_code     <= 2'd0;
        end else begin
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (!tok_kind) begin
                            if (stk_full) begin
                                r_err      <= 1'b1;
                                r_err_code <= c_ERR_OVF;
                                r_state    <= c_ST_DRAIN;
                            end
                        end else if (tok_data[2:0] == c_OP_EQ) begin
                            r_state <= c_ST_POP_F;
                        end else if (tok_data[2:0] == c_OP_ILL) begin
                            r_err      <= 1'b1;
                            r_err_code <= c_ERR_ILL;
                            r_state    <= c_ST_DRAIN;
                        end else begin
                            r_op    <= tok_data[2:0];
                            r_state <= c_ST_POP_B;
                        end
                    end
                end
                c_ST_POP_B: begin
                    if (stk_empty) begin
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_UNF;
                        r_state    <= c_ST_DRAIN;
                    end else begin
                        r_b     <= stk_value_out;
                        r_state <= c_ST_POP_A;
                    end
                end
                c_ST_POP_A: begin
                    if (stk_empty) begin
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_UNF;
                        r_state    <= c_ST_DRAIN;
                    end else begin
                        r_a     <= stk_value_out;
                        r_state <= c_ST_PUSH_R;
                    end
                end
                c_ST_PUSH_R: r_state <= c_ST_IDLE;
                c_ST_POP_F: begin
                    if (stk_empty) begin
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_UNF;
                        r_state    <= c_ST_DRAIN;
                    end else begin
                        r_result <= stk_value_out;
                        r_state  <= c_ST_CHECK;
                    end
                end
                c_ST_CHECK: begin
                    if (stk_empty) begin
                        r_result_valid <= 1'b1;
                        r_state        <= c_ST_IDLE;
                    end else begin
                        r_err      <= 1'b1;
                        r_err_code <= c_ERR_LEFT;
                        r_state    <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    if (stk_empty) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign err          = r_err;
    assign err_code     = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_rpn_eval.sv
//==============================================================================
// Module      : tb_rpn_eval
// Description : Bench for rpn_eval. Provides a small behavioural stack of
//               depth DEPTH, a token-level RPN reference model with expected
//               pulse timing, directed scenarios and a randomized token run.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rpn_eval;

    localparam int DEPTH = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tok_valid = 1'b0;
    logic        tok_ready;
    logic        tok_kind = 1'b0;
    logic [15:0] tok_data = 16'h0000;
    logic        result_valid;
    logic [15:0] result;
    logic        err;
    logic [1:0]  err_code;
    logic        stk_push;
    logic        stk_pop;
    logic [15:0] stk_value_in;
    logic [15:0] stk_value_out;
    logic        stk_full;
    logic        stk_empty;

    always #5 clk = ~clk;

    rpn_eval u_dut (
        .clk           (clk),
        .reset         (reset),
        .tok_valid     (tok_valid),
        .tok_ready     (tok_ready),
        .tok_kind      (tok_kind),
        .tok_data      (tok_data),
        .result_valid  (result_valid),
        .result        (result),
        .err           (err),
        .err_code      (err_code),
        .stk_push      (stk_push),
        .stk_pop       (stk_pop),
        .stk_value_in  (stk_value_in),
        .stk_value_out (stk_value_out),
        .stk_full      (stk_full),
        .stk_empty     (stk_empty)
    );

    // ---------------- behavioural stack ----------------
    logic [15:0] smem [DEPTH];
    int          scount = 0;

    always @(posedge clk) begin
        if (reset) begin
            scount <= 0;
        end else if (stk_push && scount < DEPTH) begin
            smem[scount] <= stk_value_in;
            scount       <= scount + 1;
        end else if (stk_pop && scount > 0) begin
            scount <= scount - 1;
        end
    end

    assign stk_full      = (scount == DEPTH);
    assign stk_empty     = (scount == 0);
    assign stk_value_out = (scount == 0) ? 16'h0000 : smem[scount-1];

    // ---------------- checking bookkeeping ----------------
    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [15:0] val;
        int          at;
    } ev_t;

    ev_t         evq[$];
    logic [15:0] mstk[$];
    logic [15:0] m_result = 16'h0000;
    logic [1:0]  m_code = 2'd0;
    bit          pending = 1'b0;
    int          exp_ready = 0;
    bit          acc_flag = 1'b0;
    int          cyc = 0;
    bit          rst_q = 1'b0;
    int          rv_cnt = 0;
    int          err_cnt = 0;
    int          pop_cnt = 0;
    int          push_cnt = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    function automatic ev_t mk_ev(bit e, logic [1:0] c, logic [15:0] v, int at);
        ev_t x;
        x.is_err = e;
        x.code   = c;
        x.val    = v;
        x.at     = at;
        return x;
    endfunction

    function automatic logic [15:0] m_alu(logic [2:0] op, logic [15:0] a, logic [15:0] b);
        int s;
        case (op)
            3'd0, 3'd1: begin
                s = (op == 3'd0) ? int'($signed(a)) + int'($signed(b))
                                 : int'($signed(a)) - int'($signed(b));
`ifdef RPN_EVAL_SAT_EN
                if (s > 32767)  s = 32767;
                if (s < -32768) s = -32768;
`endif
                return 16'(s);
            end
            3'd2: return 16'(a * b);
            3'd3: return a & b;
            3'd4: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Token-level RPN semantics; records expected pulses with their cycle and
    // the cycle at which tok_ready must next be seen high.
    function automatic void model_tok(bit k, logic [15:0] d);
        logic [15:0] a, b, r;
        int rem;
        pending = 1'b1;
        if (!k) begin
            if (mstk.size() == DEPTH) begin
                evq.push_back(mk_ev(1'b1, 2'd0, 16'h0, cyc + 1));
                m_code    = 2'd0;
                exp_ready = cyc + 1 + DEPTH + 1;
                mstk.delete();
            end else begin
                mstk.push_back(d);
                exp_ready = cyc + 1;
            end
        end else if (d[2:0] == 3'd6) begin
            evq.push_back(mk_ev(1'b1, 2'd3, 16'h0, cyc + 1));
            m_code    = 2'd3;
            exp_ready = cyc + 1 + mstk.size() + 1;
            mstk.delete();
        end else if (d[2:0] == 3'd7) begin
            if (mstk.size() == 0) begin
                evq.push_back(mk_ev(1'b1, 2'd1, 16'h0, cyc + 2));
                m_code    = 2'd1;
                exp_ready = cyc + 3;
            end else begin
                r        = mstk.pop_back();
                m_result = r;
                rem      = mstk.size();
                if (rem == 0) begin
                    evq.push_back(mk_ev(1'b0, 2'd0, r, cyc + 3));
                    exp_ready = cyc + 3;
                end else begin
                    evq.push_back(mk_ev(1'b1, 2'd2, r, cyc + 3));
                    m_code    = 2'd2;
                    exp_ready = cyc + 3 + rem + 1;
                    mstk.delete();
                end
            end
        end else begin
            if (mstk.size() == 0) begin
                evq.push_back(mk_ev(1'b1, 2'd1, 16'h0, cyc + 2));
                m_code    = 2'd1;
                exp_ready = cyc + 3;
            end else if (mstk.size() == 1) begin
                mstk.delete();
                evq.push_back(mk_ev(1'b1, 2'd1, 16'h0, cyc + 3));
                m_code    = 2'd1;
                exp_ready = cyc + 4;
            end else begin
                b = mstk.pop_back();
                a = mstk.pop_back();
                mstk.push_back(m_alu(d[2:0], a, b));
                exp_ready = cyc + 4;
            end
        end
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            chk("rst_tok_ready", tok_ready, 0);
            chk("rst_push", stk_push, 0);
            chk("rst_pop", stk_pop, 0);
            chk("rst_value_in", stk_value_in, 0);
            if (rst_q) begin
                chk("rst_result_valid", result_valid, 0);
                chk("rst_err", err, 0);
                chk("rst_result", result, 0);
                chk("rst_err_code", err_code, 0);
            end
            mstk.delete();
            evq.delete();
            m_result = 16'h0000;
            m_code   = 2'd0;
            pending  = 1'b0;
        end else begin
            if (stk_push && stk_pop) chk("push_pop_excl", {stk_push, stk_pop}, 2'b10);
            if (stk_pop)  pop_cnt++;
            if (stk_push) push_cnt++;
            if (result_valid) rv_cnt++;
            if (err) err_cnt++;
            if (result_valid || err) begin
                if (evq.size() == 0) begin
                    chk("unexpected_pulse", {result_valid, err}, 2'b00);
                end else begin
                    e = evq.pop_front();
                    chk("pulse_err", err, e.is_err);
                    chk("pulse_rv", result_valid, !e.is_err);
                    chk("pulse_cycle", cyc, e.at);
                    if (e.is_err) chk("err_code", err_code, e.code);
                    if (!e.is_err || e.code == 2'd2) chk("result", result, e.val);
                end
            end
            if (evq.size() > 0 && evq[0].at < cyc) begin
                e = evq.pop_front();
                chk("missing_pulse", {result_valid, err}, {!e.is_err, e.is_err});
            end
            if (pending) begin
                if (tok_ready) begin
                    chk("ready_cycle", cyc, exp_ready);
                    pending = 1'b0;
                end else if (cyc > exp_ready + 8) begin
                    chk("ready_timeout", tok_ready, 1);
                    pending = 1'b0;
                end
            end
            if (tok_ready && !pending) begin
                chk("idle_result", result, m_result);
                chk("idle_err_code", err_code, m_code);
                chk("idle_depth", scount, mstk.size());
                chk("idle_no_outstanding", evq.size(), 0);
            end
            if (tok_valid && tok_ready) begin
                model_tok(tok_kind, tok_data);
                acc_flag = 1'b1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(bit k, logic [15:0] d);
        int n = 0;
        acc_flag  = 1'b0;
        tok_kind  = k;
        tok_data  = d;
        tok_valid = 1'b1;
        do begin
            @(posedge clk);
            n++;
        end while (!acc_flag && n < 100);
        if (!acc_flag) chk("send_timeout", acc_flag, 1);
        acc_flag = 1'b0;
        #1;
        tok_valid = 1'b0;
    endtask

    task automatic opnd(logic [15:0] v);
        send(1'b0, v);
    endtask

    task automatic oper(logic [2:0] op);
        send(1'b1, {13'h0, op});
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tok_ready && !pending && evq.size() == 0) && n < 200);
        if (n >= 200) chk("idle_timeout", tok_ready, 1);
        @(posedge clk);
        #1;
    endtask

    logic [15:0] edge_v [4];
    int          rv0, er0, pop0, push0;

    initial begin
        edge_v[0] = 16'h7FFF;
        edge_v[1] = 16'h8000;
        edge_v[2] = 16'hFFFF;
        edge_v[3] = 16'h0001;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // 3 4 + 5 * =
        rv0 = rv_cnt; er0 = err_cnt;
        opnd(16'd3); opnd(16'd4); oper(3'd0); opnd(16'd5); oper(3'd2); oper(3'd7);
        wait_idle();
        chk("t1_result", result, 16'h0023);
        chk("t1_rv_count", rv_cnt - rv0, 1);
        chk("t1_err_count", err_cnt - er0, 0);
        chk("t1_empty", stk_empty, 1);

        // 2 5 - =
        opnd(16'd2); opnd(16'd5); oper(3'd1); oper(3'd7);
        wait_idle();
        chk("t2_sub", result, 16'hFFFD);

        // 7FFF 1 + =
        opnd(16'h7FFF); opnd(16'h0001); oper(3'd0); oper(3'd7);
        wait_idle();
`ifdef RPN_EVAL_SAT_EN
        chk("t2_add_edge", result, 16'h7FFF);
`else
        chk("t2_add_edge", result, 16'h8000);
`endif

        // 1 + -> underflow, then 6 = -> 6
        er0 = err_cnt;
        opnd(16'd1); oper(3'd0);
        wait_idle();
        chk("t3_err_code", err_code, 1);
        chk("t3_err_count", err_cnt - er0, 1);
        chk("t3_empty", stk_empty, 1);
        opnd(16'd6); oper(3'd7);
        wait_idle();
        chk("t3_result", result, 16'h0006);

        // fill to full then overflow
        for (int i = 0; i < DEPTH; i++) opnd(16'(i + 10));
        @(negedge clk);
        chk("t4_full", stk_full, 1);
        @(posedge clk); #1;
        pop0 = pop_cnt; push0 = push_cnt;
        opnd(16'h00AA);
        wait_idle();
        chk("t4_err_code", err_code, 0);
        chk("t4_drain_pops", pop_cnt - pop0, DEPTH);
        chk("t4_no_push", push_cnt - push0, 0);

        // 1 2 = -> leftover
        rv0 = rv_cnt;
        opnd(16'd1); opnd(16'd2);
        pop0 = pop_cnt;
        oper(3'd7);
        wait_idle();
        chk("t5_result", result, 16'h0002);
        chk("t5_err_code", err_code, 2);
        chk("t5_no_rv", rv_cnt - rv0, 0);
        chk("t5_pops", pop_cnt - pop0, 2);

        // illegal opcode
        pop0 = pop_cnt; push0 = push_cnt;
        oper(3'd6);
        wait_idle();
        chk("t5_ill_code", err_code, 3);
        chk("t5_ill_stack", (pop_cnt - pop0) + (push_cnt - push0), 0);

        // reset during POP_A of 9 8 ^
        opnd(16'd9); opnd(16'd8); oper(3'd5);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_result", result, 0);
        chk("t6_err_code", err_code, 0);
        chk("t6_rv_err", {result_valid, err}, 0);
        chk("t6_stk_cmd", {stk_push, stk_pop, tok_ready}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_ready", tok_ready, 1);
        chk("t6_empty", stk_empty, 1);
        @(posedge clk); #1;

        // randomized token stream
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 55) begin
                if ($urandom_range(0, 3) == 0) opnd(edge_v[$urandom_range(0, 3)]);
                else opnd(16'($urandom));
            end else if (r < 88) begin
                send(1'b1, {13'($urandom), 3'($urandom_range(0, 5))});
            end else if (r < 97) begin
                send(1'b1, {13'($urandom), 3'd7});
            end else begin
                send(1'b1, {13'($urandom), 3'd6});
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        chk("end_outstanding", evq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
